// File: rtl/ling16_stream_accum.sv
// Packet accumulator around a 16-bit Ling adder core: one total per packet, 1-cycle result latency, valid/ready output.
// Optional LING_ACC_SAT_EN: clamp the accumulator at 16'hFFFF on carry-out instead of wrapping.

module L16_node_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);
  logic [15:0] g, t, p;
  logic [4:0][15:0] gk, pk;
  logic [15:0] c;

  assign g = a & b;
  assign t = a | b;
  assign p = a ^ b;

  // Ling pseudo-carry H[i] = g[i] | t[i-1] & H[i-1], solved with a log-depth prefix tree
  assign gk[0] = g;
  assign pk[0] = {t[14:0], 1'b0};

  for (genvar l = 0; l < 4; l++) begin : g_lvl
    for (genvar i = 0; i < 16; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_op
        assign gk[l+1][i] = gk[l][i] | (pk[l][i] & gk[l][i-(1<<l)]);
        assign pk[l+1][i] = pk[l][i] & pk[l][i-(1<<l)];
      end else begin : g_pass
        assign gk[l+1][i] = gk[l][i];
        assign pk[l+1][i] = pk[l][i];
      end
    end
  end

  // Real carry out of bit i recovered from the pseudo-carry
  assign c = t & gk[4];
  assign sum = p ^ {c[14:0], 1'b0};
endmodule

module ling16_stream_accum #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic [15:0]      acc, sum, acc_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             ovf, ovf_nxt, c16, accept;

  L16_node_adder u_add (
    .a   (acc),
    .b   (in_data),
    .sum (sum)
  );

  assign c16    = (acc[15] & in_data[15]) | ((acc[15] ^ in_data[15]) & ~sum[15]);
  assign accept = in_valid & in_ready;

  always_comb begin
    count_nxt = (count == CNT_MAX) ? count : count + 1'b1;
    ovf_nxt   = ovf | c16;
`ifdef LING_ACC_SAT_EN
    acc_nxt   = c16 ? 16'hFFFF : sum;
`else
    acc_nxt   = sum;
`endif
    // acc is zero in IDLE, so the core output is in_data and c16 is 0
    if (state == IDLE) begin
      count_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
      ovf_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: if (accept) state_nxt = in_last ? HOLD : ACCUM;
      HOLD:        if (out_ready) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state != HOLD);
    out_valid = (state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else if (accept) begin
      acc   <= acc_nxt;
      count <= count_nxt;
      ovf   <= ovf_nxt;
      if (in_last) begin
        out_sum   <= acc_nxt;
        out_ovf   <= ovf_nxt;
        out_count <= count_nxt;
      end
    end else if (state == HOLD && out_ready) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end
  end
endmodule
